// File: rtl/window_stream_ctrl.sv
// window_stream_ctrl
//   Drives the pixel-window shift register from a valid/ready raster stream
//   and tags every centred window with its centre coordinates, a border flag
//   and end-of-frame.
//   One window is produced per frame pixel. The first window appears only
//   after the lag of L = HH*frameW + HW pushes. After the last input pixel,
//   L pad pixels are pushed to drain the tail.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        asynchronous active-high reset
//   in_valid   input pixel valid
//   in_ready   pixel accepted this cycle (low during FLUSH and reset)
//   in_data    input pixel
//   in_sof     input pixel is frame pixel (0,0)
//   sr_shift   shift-register enable (combinational)
//   sr_data    pixel to shift in (combinational)
//   win_valid  window register holds a valid centred window
//   win_x      centre column
//   win_y      centre row
//   win_border window extends past a frame edge
//   win_eof    last window of the frame
//   busy       state != IDLE
//   frame_err  (WSC_FRAME_ERR_EN only) one-cycle pulse when in_sof arrives
//              mid-frame; the frame restarts with that pixel
//
// Build option
//   WSC_FRAME_ERR_EN : adds frame_err and mid-frame sof restart.
//                      When it is undefined, in_sof in RUN is an ordinary pixel.
//
// state | meaning
// IDLE  | waiting for sof; non-sof pixels are accepted and dropped
// RUN   | pushing accepted frame pixels
// FLUSH | pushing PAD for L cycles to drain the last windows
module window_stream_ctrl #(
    parameter int dataDept = 8,
    parameter int frameW   = 640,
    parameter int frameH   = 480,
    parameter int windowW  = 3,
    parameter int windowH  = 3,
    parameter logic [dataDept-1:0] PAD = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [dataDept-1:0] in_data,
    input  logic                in_sof,
    output logic                sr_shift,
    output logic [dataDept-1:0] sr_data,
    output logic                win_valid,
    output logic [15:0]         win_x,
    output logic [15:0]         win_y,
    output logic                win_border,
    output logic                win_eof,
`ifdef WSC_FRAME_ERR_EN
    output logic                frame_err,
`endif
    output logic                busy
);

    localparam int HW = (windowW - 1) / 2;
    localparam int HH = (windowH - 1) / 2;
    localparam int L  = HH * frameW + HW;
    localparam int N  = frameW * frameH;

    localparam logic [31:0] L32   = 32'(L);
    localparam logic [31:0] N_M1  = 32'(N - 1);
    localparam logic [15:0] X_MAX = 16'(frameW - 1);
    localparam logic [15:0] Y_MAX = 16'(frameH - 1);
    localparam logic [15:0] X_LO  = 16'(HW);
    localparam logic [15:0] X_HI  = 16'(frameW - 1 - HW);
    localparam logic [15:0] Y_LO  = 16'(HH);
    localparam logic [15:0] Y_HI  = 16'(frameH - 1 - HH);
    localparam bit NO_LAG  = (L == 0);
    localparam bit ONE_PIX = (N == 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t      state;
    logic [31:0] count;      // accepted pixels of the current frame
    logic [31:0] lag_cnt;    // pushes still to go before windows start
    logic [31:0] flush_cnt;  // pad pushes remaining
    logic [15:0] cx, cy;     // centre of the next window to emit

    logic        start, last, emit;
    logic [15:0] cur_x, cur_y, nxt_x, nxt_y;

    assign busy = (state != IDLE);

    always_comb begin
        in_ready = 1'b0;
        sr_shift = 1'b0;
        sr_data  = '0;
        start    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    sr_data  = in_data;
                    start    = in_valid & in_sof;
                    sr_shift = start;
                end
                RUN: begin
                    in_ready = 1'b1;
                    sr_data  = in_data;
                    sr_shift = in_valid;
`ifdef WSC_FRAME_ERR_EN
                    start    = in_valid & in_sof;
`endif
                end
                FLUSH: begin
                    sr_shift = 1'b1;
                    sr_data  = PAD;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        last = 1'b0;
        if (start)
            last = ONE_PIX;
        else if (state == RUN && in_valid && count == N_M1)
            last = 1'b1;
    end

    // A sof push restarts the lag, so it can only produce a window when L=0.
    assign emit  = sr_shift & (start ? NO_LAG : (lag_cnt == 32'd0));
    assign cur_x = start ? 16'd0 : cx;
    assign cur_y = start ? 16'd0 : cy;

    always_comb begin
        nxt_x = cur_x + 16'd1;
        nxt_y = cur_y;
        if (cur_x == X_MAX) begin
            nxt_x = 16'd0;
            nxt_y = (cur_y == Y_MAX) ? 16'd0 : cur_y + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            lag_cnt    <= '0;
            flush_cnt  <= '0;
            cx         <= '0;
            cy         <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            win_border <= 1'b0;
            win_eof    <= 1'b0;
`ifdef WSC_FRAME_ERR_EN
            frame_err  <= 1'b0;
`endif
        end else begin
            win_valid <= emit;
            win_eof   <= emit & (cur_x == X_MAX) & (cur_y == Y_MAX);
            if (emit) begin
                win_x      <= cur_x;
                win_y      <= cur_y;
                win_border <= (cur_x < X_LO) | (cur_x > X_HI) |
                              (cur_y < Y_LO) | (cur_y > Y_HI);
                cx         <= nxt_x;
                cy         <= nxt_y;
            end else if (start) begin
                cx <= '0;
                cy <= '0;
            end

            if (start)
                lag_cnt <= NO_LAG ? 32'd0 : L32 - 32'd1;
            else if (sr_shift && lag_cnt != 32'd0)
                lag_cnt <= lag_cnt - 32'd1;

            if (start)
                count <= 32'd1;
            else if (state == RUN && in_valid)
                count <= count + 32'd1;

`ifdef WSC_FRAME_ERR_EN
            frame_err <= start & (state == RUN);
`endif

            case (state)
                IDLE, RUN: begin
                    if (last) begin
                        state     <= NO_LAG ? IDLE : FLUSH;
                        flush_cnt <= L32;
                    end else if (start) begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 32'd1;
                    if (flush_cnt == 32'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Directed bench for window_stream_ctrl: 8x4 frame, 3x3 window (L=9, N=32).
module tb_window_stream_ctrl;

    localparam logic [7:0] PADV = 8'hA5;

    logic        clk, rst, in_valid, in_ready, in_sof, sr_shift;
    logic [7:0]  in_data, sr_data;
    logic        win_valid, win_border, win_eof, busy;
    logic [15:0] win_x, win_y;
`ifdef WSC_FRAME_ERR_EN
    logic        frame_err;
`endif

    window_stream_ctrl #(
        .dataDept(8), .frameW(8), .frameH(4), .windowW(3), .windowH(3), .PAD(PADV)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .sr_shift(sr_shift), .sr_data(sr_data),
        .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
        .win_border(win_border), .win_eof(win_eof),
`ifdef WSC_FRAME_ERR_EN
        .frame_err(frame_err),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // monitor state
    int push_n, win_n, eof_n, pad_n, stall_n, err_n;
    int clr_req = 0;
    int clr_seen = 0;
    logic [15:0] wx [64];
    logic [15:0] wy [64];
    logic        wb [64];
    logic        we [64];
    int          wp [64];
    logic [7:0]  pd [64];

    always @(negedge clk) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            push_n = 0; win_n = 0; eof_n = 0; pad_n = 0; stall_n = 0; err_n = 0;
        end
        if (win_valid && win_n < 64) begin
            wx[win_n] = win_x; wy[win_n] = win_y;
            wb[win_n] = win_border; we[win_n] = win_eof;
            wp[win_n] = push_n;
            win_n++;
        end
        if (win_eof) eof_n++;
        if (sr_shift) begin
            if (push_n < 64) pd[push_n] = sr_data;
            push_n++;
        end
        if (!rst && !in_ready) begin
            stall_n++;
            if (sr_shift && sr_data == PADV) pad_n++;
        end
`ifdef WSC_FRAME_ERR_EN
        if (frame_err) err_n++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_pixels(input int from, input int to, input int extra_sof, input int gap);
        bit acc;
        for (int p = from; p <= to; p++) begin
            for (int g = 0; g < 4 && int'($urandom_range(99)) < gap; g++) begin
                in_valid = 1'b0; in_sof = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = 8'(p) + 8'h10;
            in_sof   = (p == 0) || (p == extra_sof);
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) check($sformatf("accept timeout px%0d", p), 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 200);
        check({tag, " idle timeout"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic verify(input string tag, input int exp_err);
        int x, y;
        check({tag, " windows"}, 32'(win_n), 32'd32);
        check({tag, " pushes"}, 32'(push_n), 32'd41);
        check({tag, " eof count"}, 32'(eof_n), 32'd1);
        check({tag, " stall cycles"}, 32'(stall_n), 32'd9);
        check({tag, " pad pushes"}, 32'(pad_n), 32'd9);
`ifdef WSC_FRAME_ERR_EN
        check({tag, " frame_err"}, 32'(err_n), 32'(exp_err));
`else
        if (exp_err != 0) check({tag, " frame_err unsupported"}, 32'(exp_err), 32'd0);
`endif
        for (int i = 0; i < 32 && i < win_n; i++) begin
            x = i % 8;
            y = i / 8;
            check($sformatf("%s x[%0d]", tag, i), 32'(wx[i]), 32'(x));
            check($sformatf("%s y[%0d]", tag, i), 32'(wy[i]), 32'(y));
            check($sformatf("%s border[%0d]", tag, i), 32'(wb[i]),
                  32'(x == 0 || x == 7 || y == 0 || y == 3));
            check($sformatf("%s eof[%0d]", tag, i), 32'(we[i]), 32'(i == 31));
            check($sformatf("%s push[%0d]", tag, i), 32'(wp[i]), 32'(i + 10));
        end
        for (int i = 0; i < 41 && i < push_n; i++)
            check($sformatf("%s data[%0d]", tag, i), 32'(pd[i]),
                  (i < 32) ? 32'(8'(i) + 8'h10) : 32'(PADV));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_data = 8'h33;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst sr_shift", 32'(sr_shift), 32'd0);
        check("rst sr_data", 32'(sr_data), 32'd0);
        check("rst win_valid", 32'(win_valid), 32'd0);
        check("rst win_x", 32'(win_x), 32'd0);
        check("rst win_y", 32'(win_y), 32'd0);
        check("rst win_border", 32'(win_border), 32'd0);
        check("rst win_eof", 32'(win_eof), 32'd0);
        check("rst busy", 32'(busy), 32'd0);

        // non-sof pixel in IDLE: accepted and dropped
        @(posedge clk); #1;
        rst = 1'b0; in_sof = 1'b0;
        @(negedge clk);
        check("idle in_ready", 32'(in_ready), 32'd1);
        check("idle sr_shift", 32'(sr_shift), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        clr_req++;
        drive_pixels(0, 31, -1, 0);
        wait_idle("bb");
        verify("bb", 0);

        clr_req++;
        drive_pixels(0, 31, -1, 50);
        wait_idle("gap");
        verify("gap", 0);

`ifdef WSC_FRAME_ERR_EN
        clr_req++;
        drive_pixels(0, 19, -1, 0);
        @(posedge clk); #1;
        check("abort windows", 32'(win_n), 32'd11);
        check("abort eof", 32'(eof_n), 32'd0);
        clr_req++;
        drive_pixels(0, 31, -1, 0);
        wait_idle("restart");
        verify("restart", 1);
`else
        clr_req++;
        drive_pixels(0, 31, 20, 0);
        wait_idle("sof20");
        verify("sof20", 0);
`endif

        // reset during FLUSH
        clr_req++;
        drive_pixels(0, 31, -1, 0);
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (in_ready && t < 20);
            check("reach flush", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("flush rst busy", 32'(busy), 32'd0);
        check("flush rst win_valid", 32'(win_valid), 32'd0);
        check("flush rst sr_shift", 32'(sr_shift), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post rst busy", 32'(busy), 32'd0);
        check("post rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        clr_req++;
        drive_pixels(0, 31, -1, 0);
        wait_idle("after_rst");
        verify("after_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
